// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity codes and
// helpers that size the baud counter from the clock and line rates.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   function automatic int baud_div(input int clock_rate, input int baud_rate);
      return clock_rate / baud_rate;
   endfunction

   function automatic int cnt_width(input int max_count);
      if (max_count <= 1) return 1;
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. Push on full and pop on empty are
// ignored, so the level can never overflow or underflow.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok;
   logic             pop_ok;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart8_tx_fifo.sv
// Buffered 8-bit UART transmitter: FIFO-fed framing FSM producing start,
// LSB-first data, optional parity and one or two stop bits.
module uart8_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE   = 100000000,
   parameter int BAUD_RATE    = 9600,
   parameter int TURBO_FRAMES = 0,
   parameter int PARITY       = 0,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          txEn,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [7:0]                    wr_data,
   output logic                          tx,
   output logic                          txBusy,
   output logic                          txDone,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int BAUD_DIV = baud_div(CLOCK_RATE, BAUD_RATE);
   localparam int CNT_W    = cnt_width(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam bit   USE_PAR   = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
   localparam bit   ODD_PAR   = (PARITY == PAR_ODD);
   localparam logic [2:0] LAST_DATA = 3'd7;
   localparam logic [2:0] LAST_STOP = (TURBO_FRAMES != 0) ? 3'd0 : 3'd1;

   tx_state_t        state_q, state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_rd_data;
   logic             can_start;
   logic             bit_end;
   logic             launch;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (wr_valid),
      .wr_data (wr_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign wr_ready  = !fifo_full;
   assign can_start = txEn && !fifo_empty;
   assign bit_end   = (baud_cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      fifo_pop   = 1'b0;
      launch     = 1'b0;
      if (state_q != IDLE && !bit_end) baud_cnt_d = baud_cnt_q - 1'b1;
      case (state_q)
         IDLE:  launch = can_start;
         START: if (bit_end) begin
            state_d    = DATA;
            baud_cnt_d = BAUD_LAST;
         end
         DATA: if (bit_end) begin
            baud_cnt_d = BAUD_LAST;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == LAST_DATA) begin
               bit_cnt_d = '0;
               state_d   = USE_PAR ? PAR : STOP;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         PAR: if (bit_end) begin
            state_d    = STOP;
            baud_cnt_d = BAUD_LAST;
            bit_cnt_d  = '0;
         end
         STOP: if (bit_end) begin
            if (bit_cnt_q == LAST_STOP) begin
               // Chaining straight into START keeps back-to-back frames gapless.
               launch  = can_start;
               state_d = IDLE;
            end else begin
               bit_cnt_d  = bit_cnt_q + 1'b1;
               baud_cnt_d = BAUD_LAST;
            end
         end
         default: state_d = IDLE;
      endcase
      if (launch) begin
         fifo_pop   = 1'b1;
         shift_d    = fifo_rd_data;
         par_d      = (^fifo_rd_data) ^ ODD_PAR;
         state_d    = START;
         baud_cnt_d = BAUD_LAST;
         bit_cnt_d  = '0;
      end
   end

   // Outputs are registered from the next state so tx never glitches.
   always_comb begin
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PAR:     tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (baud_cnt_d == '0) && (bit_cnt_d == LAST_STOP);
   end

   assign tx     = tx_q;
   assign txBusy = busy_q;
   assign txDone = done_q;

endmodule
